// File: rtl/filt_pkg.sv
// -----------------------------------------------------------------------------
// filt_pkg
// Shared definitions for the FIR MAC controller:
//   state_t - controller FSM states
//   clog2   - ceil(log2(n)), address width for an L-entry delay line
//   nmac    - MAC cycles per sample (halved, rounded up, when taps are paired)
// -----------------------------------------------------------------------------
package filt_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_MAC,
        ST_DUMP
    } state_t;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    function automatic int nmac(input int l, input bit symm);
        return symm ? (l + 1) / 2 : l;
    endfunction

endpackage

// File: rtl/filt_mac_ctrl_if.sv
// -----------------------------------------------------------------------------
// filt_mac_ctrl_if
// Sample handshake plus delay-line / coefficient / accumulator control bundle.
//   i_ena, i_valid          : upstream enable and sample-valid
//   o_ready                 : sample accepted this cycle when i_valid is high
//   o_wr_en/_zero/_addr     : delay-line write port control
//   o_rd_addr_a/_b          : newer-tap and mirrored-tap read addresses
//   o_pair_ena              : pre-add tap b onto tap a
//   o_coeff_addr            : coefficient index
//   o_acc_clr/_en           : accumulator load-vs-add and update
//   o_oup_load, o_done      : output register load and frame-complete pulse
// master: the controller; slave: the datapath/stimulus side.
// -----------------------------------------------------------------------------
interface filt_mac_ctrl_if #(
    parameter int AW = 4
);
    logic          i_ena;
    logic          i_valid;
    logic          o_ready;
    logic          o_wr_en;
    logic          o_wr_zero;
    logic [AW-1:0] o_wr_addr;
    logic [AW-1:0] o_rd_addr_a;
    logic [AW-1:0] o_rd_addr_b;
    logic          o_pair_ena;
    logic [AW-1:0] o_coeff_addr;
    logic          o_acc_clr;
    logic          o_acc_en;
    logic          o_oup_load;
    logic          o_done;

    modport master (
        input  i_ena, i_valid,
        output o_ready, o_wr_en, o_wr_zero, o_wr_addr,
               o_rd_addr_a, o_rd_addr_b, o_pair_ena, o_coeff_addr,
               o_acc_clr, o_acc_en, o_oup_load, o_done
    );

    modport slave (
        output i_ena, i_valid,
        input  o_ready, o_wr_en, o_wr_zero, o_wr_addr,
               o_rd_addr_a, o_rd_addr_b, o_pair_ena, o_coeff_addr,
               o_acc_clr, o_acc_en, o_oup_load, o_done
    );
endinterface

// File: rtl/filt_addr_wrap.sv
// -----------------------------------------------------------------------------
// filt_addr_wrap
// Combinational circular-buffer address: result = (base - offset) mod L.
//   base   in  AW  current write pointer, 0..L-1
//   offset in  AW  tap distance, 0..L-1
//   result out AW  wrapped read address, 0..L-1
// -----------------------------------------------------------------------------
module filt_addr_wrap #(
    parameter int L  = 16,
    parameter int AW = 4
) (
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] offset,
    output logic [AW-1:0] result
);
    // The true result is always below L <= 2**AW, so doing the whole sum
    // modulo 2**AW yields it exactly; L itself may truncate (L = 2**AW).
    localparam logic [AW-1:0] L_MOD = AW'(L);

    // NOTE: a combinational block assigns its output on every path, so no latch is inferred.
    always_comb begin
        if (base >= offset) begin
            result = base - offset;
        end else begin
            result = base + (L_MOD - offset);
        end
    end
endmodule

// File: rtl/filt_mac_ctrl.sv
// -----------------------------------------------------------------------------
// filt_mac_ctrl
// Sequencer for a single-MAC FIR filter with an L-entry circular delay line.
// After reset it zero-fills the delay line, then per accepted sample it writes
// the sample, runs NMAC multiply-accumulate cycles (optionally pairing mirrored
// taps for symmetric coefficients) and pulses the output-register load.
//   i_clk    : clock
//   i_rst_an : asynchronous active-low reset
//   bus      : filt_mac_ctrl_if.master (handshake and datapath controls)
// -----------------------------------------------------------------------------
module filt_mac_ctrl
    import filt_pkg::*;
#(
    parameter int gp_coeff_length = 16,
    parameter int gp_symm         = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_an,
    filt_mac_ctrl_if.master   bus
);
    localparam int L    = gp_coeff_length;
    localparam int AW   = clog2(L);
    localparam bit SYMM = (gp_symm != 0);
    localparam bit ODD  = (L % 2) == 1;
    localparam int NMAC = nmac(L, SYMM);

    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] K_LAST   = AW'(NMAC - 1);
    localparam logic [AW-1:0] L_LAST   = AW'(L - 1);
    localparam logic [AW-1:0] MID      = AW'((L - 1) / 2);
    localparam logic [AW:0]   INIT_END = (AW + 1)'(L);

    state_t        state;
    logic [AW-1:0] k;
    logic [AW-1:0] wp;
    logic [AW:0]   init_cnt;

    // Output registers; the state register describes the cycle being shown.
    logic          wr_en_q;
    logic          wr_zero_q;
    logic [AW-1:0] wr_addr_q;
    logic [AW-1:0] rd_a_q;
    logic [AW-1:0] rd_b_q;
    logic          pair_q;
    logic [AW-1:0] coeff_q;
    logic          acc_clr_q;
    logic          acc_en_q;
    logic          oup_load_q;
    logic          done_q;

    // Values for the MAC cycle about to be entered.
    logic [AW-1:0] k_next;
    logic [AW-1:0] offset_b;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] mac_rd_b;
    logic          mac_pair;
    logic [AW-1:0] wp_inc;

    always_comb begin
        k_next   = (state == ST_MAC) ? k + ONE : '0;
        offset_b = L_LAST - k_next;
        // The centre tap of an odd-length symmetric filter has no partner.
        mac_pair = SYMM && !(ODD && (k_next == MID));
        mac_rd_b = SYMM ? addr_b : '0;
        wp_inc   = (wp == L_LAST) ? '0 : wp + ONE;
    end

    filt_addr_wrap #(.L(L), .AW(AW)) u_wrap_a (
        .base   (wp),
        .offset (k_next),
        .result (addr_a)
    );

    filt_addr_wrap #(.L(L), .AW(AW)) u_wrap_b (
        .base   (wp),
        .offset (offset_b),
        .result (addr_b)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state      <= ST_INIT;
            k          <= '0;
            wp         <= '0;
            init_cnt   <= '0;
            wr_en_q    <= 1'b0;
            wr_zero_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            pair_q     <= 1'b0;
            coeff_q    <= '0;
            acc_clr_q  <= 1'b0;
            acc_en_q   <= 1'b0;
            oup_load_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (bus.i_ena) begin
            // Strobes and read-side addresses are live only in the cycle that
            // sets them; everything below re-asserts what the next cycle needs.
            wr_en_q    <= 1'b0;
            wr_zero_q  <= 1'b0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            pair_q     <= 1'b0;
            coeff_q    <= '0;
            acc_clr_q  <= 1'b0;
            acc_en_q   <= 1'b0;
            oup_load_q <= 1'b0;
            done_q     <= 1'b0;

            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_END) begin
                        state     <= ST_IDLE;
                        wr_addr_q <= wp;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_zero_q <= 1'b1;
                        wr_addr_q <= init_cnt[AW-1:0];
                        init_cnt  <= init_cnt + (AW + 1)'(1);
                    end
                end

                ST_IDLE: begin
                    if (bus.i_valid) begin
                        state     <= ST_MAC;
                        k         <= k_next;
                        rd_a_q    <= addr_a;
                        rd_b_q    <= mac_rd_b;
                        pair_q    <= mac_pair;
                        coeff_q   <= k_next;
                        acc_clr_q <= 1'b1;
                        acc_en_q  <= 1'b1;
                    end
                end

                ST_MAC: begin
                    if (k == K_LAST) begin
                        state      <= ST_DUMP;
                        oup_load_q <= 1'b1;
                        done_q     <= 1'b1;
                    end else begin
                        k         <= k_next;
                        rd_a_q    <= addr_a;
                        rd_b_q    <= mac_rd_b;
                        pair_q    <= mac_pair;
                        coeff_q   <= k_next;
                        acc_en_q  <= 1'b1;
                    end
                end

                ST_DUMP: begin
                    state     <= ST_IDLE;
                    wp        <= wp_inc;
                    wr_addr_q <= wp_inc;
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // The ready/write handshake in IDLE is combinational so a sample is taken
    // in the same cycle it is offered. Every strobe is gated by i_ena so a
    // stall silences the datapath immediately while the registers hold.
    assign bus.o_ready      = bus.i_ena && (state == ST_IDLE);
    assign bus.o_wr_en      = bus.i_ena && (wr_en_q || ((state == ST_IDLE) && bus.i_valid));
    assign bus.o_wr_zero    = bus.i_ena && wr_zero_q;
    assign bus.o_wr_addr    = wr_addr_q;
    assign bus.o_rd_addr_a  = rd_a_q;
    assign bus.o_rd_addr_b  = rd_b_q;
    assign bus.o_pair_ena   = bus.i_ena && pair_q;
    assign bus.o_coeff_addr = coeff_q;
    assign bus.o_acc_clr    = bus.i_ena && acc_clr_q;
    assign bus.o_acc_en     = bus.i_ena && acc_en_q;
    assign bus.o_oup_load   = bus.i_ena && oup_load_q;
    assign bus.o_done       = bus.i_ena && done_q;

endmodule

// File: tb/tb_filt_mac_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filt_mac_ctrl
// Directed bench for three controller configurations sharing clock and reset:
//   u_5s : L=5 symmetric, u_4n : L=4 plain, u_4s : L=4 symmetric.
// Outputs are packed as {ready,wr_en,wr_zero,pair,acc_clr,acc_en,oup_load,done,
// wr_addr,rd_a,rd_b,coeff} with 4-bit address fields and compared against
// hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_filt_mac_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    filt_mac_ctrl_if #(.AW(3)) b5s ();
    filt_mac_ctrl_if #(.AW(2)) b4n ();
    filt_mac_ctrl_if #(.AW(2)) b4s ();

    filt_mac_ctrl #(.gp_coeff_length(5), .gp_symm(1)) u_5s (
        .i_clk(clk), .i_rst_an(rst_n), .bus(b5s.master));
    filt_mac_ctrl #(.gp_coeff_length(4), .gp_symm(0)) u_4n (
        .i_clk(clk), .i_rst_an(rst_n), .bus(b4n.master));
    filt_mac_ctrl #(.gp_coeff_length(4), .gp_symm(1)) u_4s (
        .i_clk(clk), .i_rst_an(rst_n), .bus(b4s.master));

    function automatic logic [23:0] snap5s();
        return {b5s.o_ready, b5s.o_wr_en, b5s.o_wr_zero, b5s.o_pair_ena,
                b5s.o_acc_clr, b5s.o_acc_en, b5s.o_oup_load, b5s.o_done,
                4'(b5s.o_wr_addr), 4'(b5s.o_rd_addr_a),
                4'(b5s.o_rd_addr_b), 4'(b5s.o_coeff_addr)};
    endfunction

    function automatic logic [23:0] snap4n();
        return {b4n.o_ready, b4n.o_wr_en, b4n.o_wr_zero, b4n.o_pair_ena,
                b4n.o_acc_clr, b4n.o_acc_en, b4n.o_oup_load, b4n.o_done,
                4'(b4n.o_wr_addr), 4'(b4n.o_rd_addr_a),
                4'(b4n.o_rd_addr_b), 4'(b4n.o_coeff_addr)};
    endfunction

    function automatic logic [23:0] snap4s();
        return {b4s.o_ready, b4s.o_wr_en, b4s.o_wr_zero, b4s.o_pair_ena,
                b4s.o_acc_clr, b4s.o_acc_en, b4s.o_oup_load, b4s.o_done,
                4'(b4s.o_wr_addr), 4'(b4s.o_rd_addr_a),
                4'(b4s.o_rd_addr_b), 4'(b4s.o_coeff_addr)};
    endfunction

    function automatic logic [23:0] ex(input logic [7:0] s, input int wa,
                                       input int ra, input int rb, input int ca);
        return {s, 4'(wa), 4'(ra), 4'(rb), 4'(ca)};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 3 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        rst_n       = 1'b0;
        b5s.i_ena   = 1'b1; b5s.i_valid = 1'b0;
        b4n.i_ena   = 1'b1; b4n.i_valid = 1'b0;
        b4s.i_ena   = 1'b1; b4s.i_valid = 1'b0;

        tick();
        tick();
        check("rst_5s", snap5s(), 24'h0);
        check("rst_4n", snap4n(), 24'h0);
        check("rst_4s", snap4s(), 24'h0);

        // Release reset with a sample already offered: it must wait for INIT.
        rst_n       = 1'b1;
        b5s.i_valid = 1'b1;
        #1;
        check("rel_5s", snap5s(), 24'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("init5_%0d", i), snap5s(), ex(8'h60, i, 0, 0, 0));
        end

        // Cycle 6: ready, handshake with wp=0.
        tick();
        check("hs5_0", snap5s(), ex(8'hC0, 0, 0, 0, 0));
        check("idle4n", snap4n(), ex(8'h80, 0, 0, 0, 0));
        check("idle4s", snap4s(), ex(8'h80, 0, 0, 0, 0));

        tick(); b5s.i_valid = 1'b0; #1;
        check("s5_k0", snap5s(), ex(8'h1C, 0, 0, 1, 0));
        tick();
        check("s5_k1", snap5s(), ex(8'h14, 0, 4, 2, 1));
        tick();
        check("s5_k2", snap5s(), ex(8'h04, 0, 3, 3, 2));
        tick();
        check("s5_dump", snap5s(), ex(8'h03, 0, 0, 0, 0));
        tick();
        check("s5_idle", snap5s(), ex(8'h80, 1, 0, 0, 0));

        // L=4 plain: five back-to-back samples, valid held through MAC.
        b4n.i_valid = 1'b1; #1;
        for (int s = 0; s < 5; s++) begin
            check($sformatf("n4_hs%0d", s), snap4n(), ex(8'hC0, s % 4, 0, 0, 0));
            for (int k = 0; k < 4; k++) begin
                tick();
                if (s == 4 && k == 0) begin
                    b4n.i_valid = 1'b0;
                    #1;
                end
                check($sformatf("n4_s%0d_k%0d", s, k), snap4n(),
                      ex((k == 0) ? 8'h0C : 8'h04, s % 4, (s - k + 8) % 4, 0, k));
            end
            tick();
            check($sformatf("n4_dump%0d", s), snap4n(), ex(8'h03, s % 4, 0, 0, 0));
            tick();
        end
        check("n4_idle", snap4n(), ex(8'h80, 1, 0, 0, 0));

        // L=4 symmetric: two samples, wp=0 then wp=1.
        b4s.i_valid = 1'b1; #1;
        check("s4_hs0", snap4s(), ex(8'hC0, 0, 0, 0, 0));
        tick();
        check("s4_a_k0", snap4s(), ex(8'h1C, 0, 0, 1, 0));
        tick();
        check("s4_a_k1", snap4s(), ex(8'h14, 0, 3, 2, 1));
        tick();
        check("s4_a_dump", snap4s(), ex(8'h03, 0, 0, 0, 0));
        tick();
        check("s4_hs1", snap4s(), ex(8'hC0, 1, 0, 0, 0));
        tick(); b4s.i_valid = 1'b0; #1;
        check("s4_b_k0", snap4s(), ex(8'h1C, 1, 1, 2, 0));
        tick();
        check("s4_b_k1", snap4s(), ex(8'h14, 1, 0, 3, 1));
        tick();
        check("s4_b_dump", snap4s(), ex(8'h03, 1, 0, 0, 0));
        tick();
        check("s4_idle", snap4s(), ex(8'h80, 2, 0, 0, 0));

        // L=5 symmetric, wp=1: enable dropped for 3 cycles while k=1.
        b5s.i_valid = 1'b1; #1;
        check("st_hs", snap5s(), ex(8'hC0, 1, 0, 0, 0));
        tick(); b5s.i_valid = 1'b0; #1;
        check("st_k0", snap5s(), ex(8'h1C, 1, 1, 2, 0));
        tick(); b5s.i_ena = 1'b0; #1;
        check("st_hold0", snap5s(), ex(8'h00, 1, 0, 3, 1));
        tick();
        check("st_hold1", snap5s(), ex(8'h00, 1, 0, 3, 1));
        tick();
        check("st_hold2", snap5s(), ex(8'h00, 1, 0, 3, 1));
        tick(); b5s.i_ena = 1'b1; #1;
        check("st_k1", snap5s(), ex(8'h14, 1, 0, 3, 1));
        tick();
        check("st_k2", snap5s(), ex(8'h04, 1, 4, 4, 2));
        tick();
        check("st_dump", snap5s(), ex(8'h03, 1, 0, 0, 0));
        tick();
        check("st_idle", snap5s(), ex(8'h80, 2, 0, 0, 0));

        // L=5 symmetric, wp=2: reset asserted while k=2 is shown.
        b5s.i_valid = 1'b1; #1;
        check("ab_hs", snap5s(), ex(8'hC0, 2, 0, 0, 0));
        tick(); b5s.i_valid = 1'b0; #1;
        check("ab_k0", snap5s(), ex(8'h1C, 2, 2, 3, 0));
        tick();
        check("ab_k1", snap5s(), ex(8'h14, 2, 1, 4, 1));
        tick();
        check("ab_k2", snap5s(), ex(8'h04, 2, 0, 0, 2));
        rst_n = 1'b0; #1;
        check("ab_rst", snap5s(), 24'h0);
        tick();
        check("ab_nodone", snap5s(), 24'h0);
        rst_n = 1'b1; #1;
        check("ab_rel", snap5s(), 24'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("reinit5_%0d", i), snap5s(), ex(8'h60, i, 0, 0, 0));
        end
        tick();
        check("reinit_idle", snap5s(), ex(8'h80, 0, 0, 0, 0));
        b5s.i_valid = 1'b1; #1;
        check("reinit_hs", snap5s(), ex(8'hC0, 0, 0, 0, 0));
        tick(); b5s.i_valid = 1'b0; #1;
        check("reinit_k0", snap5s(), ex(8'h1C, 0, 0, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filt_mac_ctrl.md
FILT_MAC_CTRL -- requirements
Module: filt_mac_ctrl

Interface
REQ-001 Parameter gp_coeff_length, default 16: number of FIR taps L, range 2..256.
REQ-002 Parameter gp_symm, default 0: 1 means symmetric coefficients, with pre-add pairing of taps.
REQ-003 Derived constant AW = clog2(L); NMAC = gp_symm ? ceil(L/2) : L MAC cycles per sample.
REQ-004 i_clk  in  1  single clock.
REQ-005 i_rst_an  in  1  asynchronous, active-low reset.
REQ-006 i_ena  in  1  global enable; low freezes all state.
REQ-007 i_valid  in  1  input sample available.
REQ-008 o_ready  out  1  controller accepts a sample this cycle.
REQ-009 o_wr_en  out  1  delay-line write strobe.
REQ-010 o_wr_zero  out  1  write data forced to zero (init sweep).
REQ-011 o_wr_addr  out  AW  delay-line write address.
REQ-012 o_rd_addr_a  out  AW  newer-tap read address.
REQ-013 o_rd_addr_b  out  AW  mirrored-tap read address.
REQ-014 o_pair_ena  out  1  add tap b to tap a (pre-add).
REQ-015 o_coeff_addr  out  AW  coefficient index k.
REQ-016 o_acc_clr  out  1  accumulator loads product instead of adding.
REQ-017 o_acc_en  out  1  accumulator update.
REQ-018 o_oup_load  out  1  output register load.
REQ-019 o_done  out  1  one-cycle frame-complete pulse.

Function
REQ-020 The FSM SHALL have states INIT, IDLE, MAC and DUMP; all outputs SHALL be registered except o_ready and o_wr_en in IDLE.
REQ-021 INIT: for L cycles, o_wr_en=1, o_wr_zero=1 and o_wr_addr=0..L-1, then go to IDLE; o_ready=0 throughout.
REQ-022 IDLE: o_ready=1; on i_valid&&o_ready, o_wr_en=1, o_wr_addr=wp, and the next state is MAC with k=0.
REQ-023 MAC, cycle k (0..NMAC-1): o_rd_addr_a=(wp-k) mod L, o_coeff_addr=k, o_acc_en=1, and o_acc_clr=(k==0).
REQ-024 If gp_symm=1, then o_rd_addr_b=(wp-(L-1-k)) mod L and o_pair_ena=1, except o_pair_ena=0 when L is odd and k=(L-1)/2.
REQ-025 If gp_symm=0, then o_pair_ena=0 and o_rd_addr_b=0.
REQ-026 After k=NMAC-1, go to DUMP: o_oup_load=1 and o_done=1 for exactly one cycle, wp<=(wp+1) mod L, then return to IDLE.
REQ-027 Latency: handshake at cycle 0; MAC at cycles 1..NMAC; DUMP at NMAC+1; o_ready=1 again at NMAC+2; throughput is 1 sample per NMAC+2 cycles.
REQ-028 i_valid during INIT, MAC or DUMP SHALL be ignored; o_ready=0 in those states.
REQ-029 i_ena=0: state, k and wp hold; all strobes, and o_ready, SHALL be 0; on i_ena=1, operation resumes at the held k.
REQ-030 Modulo address arithmetic SHALL wrap correctly for non-power-of-2 L, without overflow of AW bits.

Reset
REQ-031 i_rst_an=0 SHALL asynchronously force state=INIT, k=0, wp=0, and all outputs to 0, including mid-frame.
REQ-032 An aborted frame SHALL produce no o_done; after reset release, a full INIT sweep SHALL precede o_ready.

Structure
REQ-033 Package filt_pkg SHALL hold the state enum, clog2 and NMAC functions.
REQ-034 Sub-module filt_addr_wrap SHALL compute (base - offset) mod L combinationally; it is instantiated twice (a and b).

Verification
REQ-035 Reset release, L=5: 5 cycles of o_wr_zero with addresses 0..4, then o_ready=1 on cycle 6.
REQ-036 L=5, symm=1, wp=0, one sample: the (a,b,pair) sequence SHALL be (0,1,1), (4,2,1), (3,3,0); o_done at cycle 4; wp=1.
REQ-037 L=4, symm=0, four back-to-back samples: o_done every 6 cycles; o_wr_addr 0,1,2,3, and the 5th sample writes 0.
REQ-038 L=4, symm=1: pairs (wp,wp-3) and (wp-1,wp-2); o_pair_ena=1 on both cycles; o_acc_clr only on the first.
REQ-039 i_ena dropped for 3 cycles at k=1: outputs held low, k=1 retained; o_done delayed by exactly 3 cycles.
REQ-040 i_rst_an asserted at k=2: all outputs 0 immediately; no o_done; the INIT sweep restarts.
